// File: rtl/gin_bus_pkg.sv
// gin_bus shared package
// Default widths and the tag type for the global input network.
package gin_bus_pkg;

  localparam int GIN_BITWIDTH        = 16;
  localparam int GIN_TAG_LENGTH      = 4;
  localparam int GIN_NUM_CONTROLLERS = 10;

  typedef logic [GIN_TAG_LENGTH-1:0] tag_t;

  // True when a controller with this ID should take the bus word.
  function automatic logic tag_hit(
    input tag_t bus_tag,
    input tag_t id
  );
    return bus_tag == id;
  endfunction

endpackage

// File: rtl/gin_bus_multicast_controller.sv
// gin_bus multicast controller
// One tag-ID scan stage plus tag-matched data gating.
module multicast_controller
  import gin_bus_pkg::*;
#(
  parameter int BITWIDTH   = GIN_BITWIDTH,
  parameter int TAG_LENGTH = GIN_TAG_LENGTH
) (
  input  logic                  clk,
  input  logic                  rstb,
  // prog: shift the tag-ID chain this cycle
  input  logic                  prog,
  input  logic                  enable,
  input  logic                  unit_ready,
  input  logic [TAG_LENGTH-1:0] tag,
  input  logic [TAG_LENGTH-1:0] scan_tag_in,
  input  logic [BITWIDTH-1:0]   input_value,
  output logic [BITWIDTH-1:0]   output_value,
  output logic                  unit_enable,
  output logic [TAG_LENGTH-1:0] scan_tag_out
);

  logic [TAG_LENGTH-1:0] tag_id_reg;
  logic                  hit;

  // Scan stage: reset clears, prog shifts, otherwise hold.
  always_ff @(posedge clk) begin
    if (rstb) begin
      tag_id_reg <= '0;
    end else if (prog) begin
      tag_id_reg <= scan_tag_in;
    end
  end

  // Delivery is gated by the bus qualifiers and an ID match.
  always_comb begin
    hit          = (tag == tag_id_reg);
    unit_enable  = enable & unit_ready & ~prog & hit;
    output_value = unit_enable ? input_value : '0;
  end

  assign scan_tag_out = tag_id_reg;

endmodule

// File: rtl/gin_bus.sv
// gin_bus top
// Broadcasts one word to a chain of tag-matched controllers.
module gin_bus
  import gin_bus_pkg::*;
#(
  parameter int BITWIDTH        = GIN_BITWIDTH,
  parameter int TAG_LENGTH      = GIN_TAG_LENGTH,
  parameter int NUM_CONTROLLERS = GIN_NUM_CONTROLLERS
) (
  input  logic                                clk,
  input  logic                                rstb,
  // prog: shift the tag-ID chain this cycle
  input  logic                                prog,
  input  logic                                enable,
  input  logic                                unit_ready,
  input  logic [TAG_LENGTH-1:0]               tag,
  input  logic [TAG_LENGTH-1:0]               scan_tag_in,
  input  logic [BITWIDTH-1:0]                 input_value,
  output logic [BITWIDTH*NUM_CONTROLLERS-1:0] output_value,
  output logic [NUM_CONTROLLERS-1:0]          unit_enable
);

  logic [BITWIDTH-1:0]   mc_output [NUM_CONTROLLERS];
  logic [TAG_LENGTH-1:0] scan_in   [NUM_CONTROLLERS];
  logic [TAG_LENGTH-1:0] scan_out  [NUM_CONTROLLERS];

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : mc_vector

    // Controller 0 takes the external scan input.
    if (k == 0) begin : head
      assign scan_in[k] = scan_tag_in;
    end else begin : link
      assign scan_in[k] = scan_out[k-1];
    end

    multicast_controller #(
      .BITWIDTH   (BITWIDTH),
      .TAG_LENGTH (TAG_LENGTH)
    ) mc (
      .clk          (clk),
      .rstb         (rstb),
      .prog         (prog),
      .enable       (enable),
      .unit_ready   (unit_ready),
      .tag          (tag),
      .scan_tag_in  (scan_in[k]),
      .input_value  (input_value),
      .output_value (mc_output[k]),
      .unit_enable  (unit_enable[k]),
      .scan_tag_out (scan_out[k])
    );

    assign output_value[k*BITWIDTH +: BITWIDTH] = mc_output[k];
  end

endmodule

// File: tb/tb_gin_bus.sv
// gin_bus testbench
// Directed plus random steps checked against a shift-list model.
module tb_gin_bus;

  localparam int BW = 16;
  localparam int TL = 4;
  localparam int NC = 10;

  logic             clk = 1'b0;
  logic             rstb;
  logic             prog;
  logic             enable;
  logic             unit_ready;
  logic [TL-1:0]    tag;
  logic [TL-1:0]    scan_tag_in;
  logic [BW-1:0]    input_value;
  logic [BW*NC-1:0] output_value;
  logic [NC-1:0]    unit_enable;

  int errors = 0;
  int checks = 0;

  logic [TL-1:0] ids [NC];
  logic [TL-1:0] dut_ids [NC];

  gin_bus #(
    .BITWIDTH        (BW),
    .TAG_LENGTH      (TL),
    .NUM_CONTROLLERS (NC)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .prog         (prog),
    .enable       (enable),
    .unit_ready   (unit_ready),
    .tag          (tag),
    .scan_tag_in  (scan_tag_in),
    .input_value  (input_value),
    .output_value (output_value),
    .unit_enable  (unit_enable)
  );

  for (genvar g = 0; g < NC; g++) begin : peek
    assign dut_ids[g] = dut.mc_vector[g].mc.tag_id_reg;
  end

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (rstb) begin
      for (int k = 0; k < NC; k++) ids[k] = '0;
    end else if (prog) begin
      for (int k = NC - 1; k > 0; k--) ids[k] = ids[k-1];
      ids[0] = scan_tag_in;
    end
    #1;
  endtask

  task automatic check_all(input string name);
    logic [NC-1:0]    eu;
    logic [BW*NC-1:0] ev;
    eu = '0;
    ev = '0;
    for (int k = 0; k < NC; k++) begin
      if (enable && unit_ready && !prog && tag == ids[k]) begin
        eu[k] = 1'b1;
        ev[k*BW +: BW] = input_value;
      end
    end
    #1;
    checks++;
    assert (unit_enable === eu) else begin
      errors++;
      $error("FAIL %s unit_enable got %b exp %b", name, unit_enable, eu);
    end
    checks++;
    assert (output_value === ev) else begin
      errors++;
      $error("FAIL %s output_value got %h exp %h", name, output_value, ev);
    end
    for (int k = 0; k < NC; k++) begin
      checks++;
      assert (dut_ids[k] === ids[k]) else begin
        errors++;
        $error("FAIL %s id[%0d] got %0d exp %0d", name, k, dut_ids[k], ids[k]);
      end
    end
  endtask

  task automatic check_ue(input string name, input logic [NC-1:0] exp);
    checks++;
    assert (unit_enable === exp) else begin
      errors++;
      $error("FAIL %s unit_enable got %b exp %b", name, unit_enable, exp);
    end
  endtask

  task automatic check_slice(input string name, input int k, input logic [BW-1:0] exp);
    checks++;
    assert (output_value[k*BW +: BW] === exp) else begin
      errors++;
      $error("FAIL %s slice%0d got %0d exp %0d", name, k, output_value[k*BW +: BW], exp);
    end
  endtask

  initial begin
    for (int k = 0; k < NC; k++) ids[k] = 'x;
    rstb = 1'b1; prog = 1'b0; enable = 1'b0; unit_ready = 1'b0;
    tag = '0; scan_tag_in = '0; input_value = '0;
    #2;
    tick();
    rstb = 1'b0;
    check_all("reset_idle");
    enable = 1'b1; unit_ready = 1'b1; tag = 4'd0; input_value = 16'hBEEF;
    check_all("reset_tag0");
    check_ue("reset_tag0_ue", '1);

    // Shift 9..0 so controller k ends with ID k.
    enable = 1'b1; unit_ready = 1'b1; prog = 1'b1; tag = 4'd0;
    for (int i = 0; i < NC; i++) begin
      scan_tag_in = TL'(NC - 1 - i);
      check_all("prog_quiet");
      tick();
    end
    prog = 1'b0;
    for (int k = 0; k < NC; k++) begin
      checks++;
      assert (dut_ids[k] === TL'(k)) else begin
        errors++;
        $error("FAIL prog_id[%0d] got %0d exp %0d", k, dut_ids[k], k);
      end
    end

    tag = 4'd3; input_value = 16'd13;
    check_all("tag3");
    check_ue("tag3_ue", 10'b0000001000);
    check_slice("tag3", 3, 16'd13);
    tag = 4'd1; input_value = 16'd11;
    check_all("tag1");
    check_slice("tag1", 1, 16'd11);
    tag = 4'd9; input_value = 16'd19;
    check_all("tag9");
    check_ue("tag9_ue", 10'b1000000000);

    unit_ready = 1'b0;
    check_all("not_ready");
    check_ue("not_ready_ue", '0);
    unit_ready = 1'b1; enable = 1'b0;
    check_all("disabled");
    check_ue("disabled_ue", '0);
    enable = 1'b1; prog = 1'b1; scan_tag_in = 4'd5;
    check_all("prog_blocks");
    check_ue("prog_blocks_ue", '0);

    // Multicast: chain ends 5,5,2 in controllers 9,8,7.
    scan_tag_in = 4'd5; tick();
    scan_tag_in = 4'd5; tick();
    scan_tag_in = 4'd2; tick();
    for (int i = 0; i < NC - 3; i++) begin
      scan_tag_in = TL'(10 + (i % 4));
      tick();
    end
    prog = 1'b0;
    tag = 4'd5; input_value = 16'd7;
    check_all("mcast");
    check_ue("mcast_ue", 10'b1100000000);
    check_slice("mcast9", 9, 16'd7);
    check_slice("mcast8", 8, 16'd7);
    tag = 4'd15;
    check_all("nomatch");
    check_ue("nomatch_ue", '0);

    // Reset mid-programming, then restart the shift.
    prog = 1'b1;
    scan_tag_in = 4'd4; tick();
    rstb = 1'b1; scan_tag_in = 4'd6; tick();
    rstb = 1'b0;
    for (int k = 0; k < NC; k++) begin
      checks++;
      assert (dut_ids[k] === '0) else begin
        errors++;
        $error("FAIL rst_mid id[%0d] got %0d exp 0", k, dut_ids[k]);
      end
    end
    scan_tag_in = 4'd7; tick();
    check_all("restart");
    prog = 1'b0; tag = 4'd7; input_value = 16'h1234;
    check_all("restart_deliver");
    check_ue("restart_ue", 10'b0000000001);

    // Random traffic with occasional programming and reset.
    for (int n = 0; n < 300; n++) begin
      rstb        = ($urandom_range(0, 39) == 0);
      prog        = ($urandom_range(0, 3) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      unit_ready  = ($urandom_range(0, 7) != 0);
      tag         = TL'($urandom_range(0, 15));
      scan_tag_in = TL'($urandom_range(0, 15));
      input_value = BW'($urandom);
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
